// File: rtl/cpu_check_pkg.sv
// Shared types and default signatures for the CPU run checker.
// Imported by the checker top and its PC stall detector.
package cpu_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PASS,
      FAIL
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE,
      FC_TIMEOUT,
      FC_HALT,
      FC_BAD_PC
   } fail_code_t;

   localparam logic [31:0] SIG_FIB  = 32'h00213d05;
   localparam logic [31:0] SIG_FACT = 32'h1c8cfc00;

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a halt when the fetch address stays unchanged for STALL_LIMIT cycles.
// The halt output is combinational from the current imAddr and the stored state.
module pc_stall_detector #(
   parameter int STALL_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic [31:0] imAddr,
   output logic        halt
);

   localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [SW-1:0] CNT_MAX = SW'(STALL_LIMIT - 1);

   logic [31:0]   prev_q;
   logic [SW-1:0] cnt_q;
   logic [SW-1:0] cnt_d;
   logic          same;

   assign same = (imAddr == prev_q);
   assign halt = !clear && same && (cnt_q == CNT_MAX);

   // Saturates so a long stall cannot wrap back below the limit.
   always_comb begin
      cnt_d = '0;
      if (same) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         prev_q <= imAddr;
         cnt_q  <= '0;
      end else begin
         prev_q <= imAddr;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_run_checker.sv
// Run monitor for the single-cycle CPU: polls debug registers for a signature,
// watches the fetch address for halt/out-of-ROM, enforces a timeout, sticky verdict.
module cpu_run_checker
   import cpu_check_pkg::*;
#(
   parameter int                         N_REGS      = 2,
   parameter logic [0:N_REGS-1][4:0]     REG_LIST    = {5'd10, 5'd11},
   parameter int                         N_SIG       = 2,
   parameter logic [0:N_SIG-1][31:0]     SIG_LIST    = {SIG_FIB, SIG_FACT},
   parameter int                         TIMEOUT     = 1000,
   parameter int                         STALL_LIMIT = 16,
   parameter int                         ROM_SIZE    = 1024,
   parameter int                         CNT_W       = $clog2(TIMEOUT + 1),
   localparam int                        SIG_W       = (N_SIG > 1) ? $clog2(N_SIG) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [31:0]       imAddr,
   input  logic [31:0]       regData,
   output logic [4:0]        regAddr,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic [SIG_W-1:0]  match_sig,
   output logic [4:0]        match_reg,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);

   if (STALL_LIMIT < 2 * N_REGS) begin : g_stall_limit_check
      $fatal(1, "cpu_run_checker: STALL_LIMIT must be at least 2*N_REGS");
   end

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_next;
   logic [4:0]       reg_addr_q, reg_addr_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   fail_code_t       fail_code_q, fail_code_d;
   logic [SIG_W-1:0] match_sig_q, match_sig_d;
   logic [4:0]       match_reg_q, match_reg_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;

   logic [N_SIG-1:0] sig_hit;
   logic             match_any;
   logic [SIG_W-1:0] match_idx;
   logic             bad_pc;
   logic             timeout_hit;
   logic             halt;
   logic             stall_clear;

   for (genvar gi = 0; gi < N_SIG; gi++) begin : g_sig
      assign sig_hit[gi] = (regData == SIG_LIST[gi]);
   end

   // Scanning from the top down leaves the lowest matching index in match_idx.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = N_SIG - 1; i >= 0; i--) begin
         if (sig_hit[i]) begin
            match_any = 1'b1;
            match_idx = SIG_W'(i);
         end
      end
   end

   assign bad_pc      = (imAddr >= 32'(ROM_SIZE));
   assign timeout_hit = (cycle_q == CNT_W'(TIMEOUT - 1));
   assign stall_clear = (state_q == IDLE);
   assign idx_next    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

   pc_stall_detector #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (stall_clear),
      .imAddr (imAddr),
      .halt   (halt)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_next;
      reg_addr_d  = REG_LIST[idx_next];
      done_d      = done_q;
      pass_d      = pass_q;
      fail_code_d = fail_code_q;
      match_sig_d = match_sig_q;
      match_reg_d = match_reg_q;
      cycle_d     = cycle_q;

      if (!run || state_q == IDLE) begin
         state_d     = run ? RUN : IDLE;
         idx_d       = '0;
         reg_addr_d  = REG_LIST[0];
         done_d      = 1'b0;
         pass_d      = 1'b0;
         fail_code_d = FC_NONE;
         match_sig_d = '0;
         match_reg_d = '0;
         cycle_d     = '0;
      end else if (state_q == RUN) begin
         cycle_d = (cycle_q == CNT_W'(TIMEOUT)) ? cycle_q : cycle_q + 1'b1;
         if (match_any) begin
            state_d     = PASS;
            done_d      = 1'b1;
            pass_d      = 1'b1;
            fail_code_d = FC_NONE;
            match_sig_d = match_idx;
            match_reg_d = reg_addr_q;
         end else if (bad_pc || halt || timeout_hit) begin
            state_d     = FAIL;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            match_sig_d = '0;
            match_reg_d = '0;
            if (bad_pc) begin
               fail_code_d = FC_BAD_PC;
            end else if (halt) begin
               fail_code_d = FC_HALT;
            end else begin
               fail_code_d = FC_TIMEOUT;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         reg_addr_q  <= REG_LIST[0];
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_code_q <= FC_NONE;
         match_sig_q <= '0;
         match_reg_q <= '0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         reg_addr_q  <= reg_addr_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_code_q <= fail_code_d;
         match_sig_q <= match_sig_d;
         match_reg_q <= match_reg_d;
         cycle_q     <= cycle_d;
      end
   end

   assign regAddr     = reg_addr_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_code   = fail_code_q;
   assign match_sig   = match_sig_q;
   assign match_reg   = match_reg_q;
   assign cycle_count = cycle_q;

endmodule

// File: doc/cpu_run_checker.md
Name: cpu_run_checker

Overview:
- Synthesizable run monitor for the single-cycle CPU. It replaces ad-hoc pass/fail loops in benches and can also be placed on an FPGA next to the CPU.
- Polls a parametrised list of architectural registers through the CPU debug port, round-robin.
- Compares each polled value against a parametrised table of expected signatures.
- Watches the fetch address for halt (PC stuck) and out-of-ROM fetches, enforces a cycle timeout, and reports a sticky verdict with diagnostics.

Parameters:
- N_REGS, 2: number of debug registers polled round-robin (1..32).
- REG_LIST, {5'd10, 5'd11}: packed array [N_REGS] of 5-bit register indices; entry 0 is polled first.
- N_SIG, 2: number of expected signatures (1..16).
- SIG_LIST, {32'h00213d05, 32'h1c8cfc00}: packed array [N_SIG] of 32-bit expected values.
- TIMEOUT, 1000: RUN cycles before a timeout failure (≥2).
- STALL_LIMIT, 16: consecutive cycles with an unchanged imAddr that count as a halt. Must be ≥ 2*N_REGS; an elaboration-time assertion enforces this.
- ROM_SIZE, 1024: instruction ROM depth in words; imAddr is a word address.
- CNT_W, $clog2(TIMEOUT+1): cycle counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  high while the CPU is out of reset; enables monitoring
- imAddr  in  32  CPU instruction memory address (word address)
- regData  in  32  CPU debug register read data, combinational from regAddr
- regAddr  out  5  debug register address driven to the CPU
- done  out  1  verdict reached (sticky)
- pass  out  1  signature matched (sticky)
- fail_code  out  2  0 none, 1 timeout, 2 halt, 3 bad_pc
- match_sig  out  $clog2(N_SIG)>0?$clog2(N_SIG):1  index of the matched signature
- match_reg  out  5  register index that matched
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen at verdict

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE; poll index 0; regAddr = REG_LIST[0]
  - done, pass, fail_code, match_sig, match_reg, cycle_count = 0
  - stall counter 0; prevImAddr 0
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - run=1 moves to RUN on the next edge. cycle_count, stall counter and poll index are cleared; prevImAddr is loaded from imAddr.
- RUN, every cycle:
  - regAddr is registered and equals REG_LIST[poll index]. regData in the same cycle belongs to that register.
  - Poll index advances modulo N_REGS; the wrap from N_REGS-1 to 0 happens without a gap.
  - cycle_count increments, saturating at TIMEOUT.
  - Match: regData equals any SIG_LIST entry. The lowest matching index wins and is written to match_sig; match_reg takes the current regAddr.
  - Halt: if imAddr == prevImAddr the stall counter increments, otherwise it clears. A halt is flagged when the counter reaches STALL_LIMIT-1 while imAddr is still unchanged.
  - bad_pc: imAddr ≥ ROM_SIZE.
  - Timeout: cycle_count == TIMEOUT-1 in this cycle.
  - When several events occur in the same cycle, priority is match > bad_pc > halt > timeout.
  - Match → PASS. Any other event → FAIL, with fail_code set to the highest-priority event.
  - The verdict appears one cycle after the detecting cycle.
- PASS: done=1, pass=1, fail_code=0.
- FAIL: done=1, pass=0, match_sig and match_reg = 0.
- PASS and FAIL are terminal. All outputs hold, cycle_count is frozen, and regAddr keeps polling.
- run=0 in any state → IDLE on the next edge, with all status outputs cleared. This is the synchronous abort, used on CPU re-reset.
- rst_n low at any time, including mid-RUN, clears everything immediately without waiting for a clock edge.

Decomposition:
- Package cpu_check_pkg holds:
  - the state_t enum (IDLE, RUN, PASS, FAIL)
  - the fail_code_t enum (FC_NONE, FC_TIMEOUT, FC_HALT, FC_BAD_PC)
  - the default signature constants SIG_FIB = 32'h00213d05 and SIG_FACT = 32'h1c8cfc00.
- Sub-module pc_stall_detector, parametrised by STALL_LIMIT:
  - inputs clk, rst_n, clear, imAddr
  - holds the prevImAddr register and stall counter
  - outputs a halt pulse.
- Signature matching stays inline as a priority encoder.

Test Plan:
1. Defaults; run rises at cycle 0; PC increments; regData for register 10 becomes 32'h00213d05 at cycle 50 → done=1, pass=1, match_sig=0, match_reg=10 by cycle 52; outputs held for 100 further cycles.
2. TIMEOUT=100; PC increments each cycle; no match → done=1, fail_code=1 when cycle_count reads 100; pass=0.
3. imAddr held at 0x12 from cycle 20; no match; STALL_LIMIT=16 → fail_code=2, verdict visible at cycle 37. A variant with 32'h1c8cfc00 in register 11 at cycle 25 → pass=1, match_sig=1, match_reg=11, no halt.
4. imAddr=1024 at cycle 5 → fail_code=3 at cycle 6. In the same cycle, a matching regData plus imAddr=1024 → PASS (priority check).
5. Abort and reset: run drops mid-RUN at cycle 30 → IDLE, all outputs 0 next cycle. rst_n pulsed low mid-RUN between clock edges → outputs 0 before the next edge; a re-run gives cycle_count restarting from 0.
6. N_REGS=3, REG_LIST={10,11,12} → regAddr sequence 10,11,12,10,… in consecutive cycles after RUN entry, with no gap at wrap.
